// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-state data memory responder (IDLE/WAIT/RESP), one request in flight.
// Optional byte-lane store enables: define DMEM_BYTE_STROBE_EN.
module dmem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
    input  logic [3:0]  req_be,
`endif
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic [31:0] RAM [0:DEPTH-1];

    logic [3:0]  req_be_w;
    logic        cur_we;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_be;
    logic        cur_err;
    logic [AW-1:0] cur_idx;
    logic [31:0] cur_rword;
    logic [31:0] wr_word_d;
    logic        enter_resp;

`ifdef DMEM_BYTE_STROBE_EN
    assign req_be_w = req_be;
`else
    assign req_be_w = 4'hF;
`endif

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // With zero wait states RESP is entered on the acceptance edge itself, so the
    // transaction is taken straight from the request inputs instead of the latches.
    always_comb begin
        cur_we    = we_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        cur_be    = be_q;
        if (state_q == IDLE) begin
            cur_we    = req_we;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
            cur_be    = req_be_w;
        end
        cur_err   = ({2'b00, cur_addr[31:2]} >= 32'(DEPTH)) || (cur_addr[1:0] != 2'b00);
        cur_idx   = cur_addr[AW+1:2];
        cur_rword = RAM[cur_idx];
        for (int i = 0; i < 4; i++) begin
            wr_word_d[8*i +: 8] = cur_be[i] ? cur_wdata[8*i +: 8] : cur_rword[8*i +: 8];
        end
        enter_resp = !reset &&
                     (((state_q == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                      ((state_q == WAIT) && (cnt_q == 4'd0)));
    end

    // Storage has no reset so preloaded contents survive it.
    always_ff @(posedge clk) begin
        if (enter_resp && cur_we && !cur_err) begin
            RAM[cur_idx] <= wr_word_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            be_q        <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        be_q    <= req_be_w;
                        cnt_q   <= WAIT_INIT;
                        state_q <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (enter_resp) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= cur_err;
                rsp_rdata_q <= (cur_we || cur_err) ? 32'd0 : cur_rword;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder (WAIT_CYCLES=2 and 0 instances).
module tb_dmem_responder;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_valid0;
    logic        req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        req_ready, req_ready0;
    logic        rsp_valid, rsp_valid0;
    logic [31:0] rsp_rdata, rsp_rdata0;
    logic        rsp_err, rsp_err0;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [2][DEPTH];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;
    vec_t vt [9];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
        .req_be(req_be),
`endif
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
        .req_be(req_be),
`endif
        .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference behaviour: word array, byte-mask merge, error on range/alignment.
    task automatic model_txn(input int sel, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be,
                             output logic [31:0] rdata, output logic err);
        int unsigned widx;
        logic [31:0] mask;
        logic [3:0]  be_eff;
`ifdef DMEM_BYTE_STROBE_EN
        be_eff = be;
`else
        be_eff = 4'hF;
`endif
        widx  = addr / 4;
        err   = (widx >= DEPTH) || (addr % 4 != 0);
        rdata = 32'd0;
        mask  = {{8{be_eff[3]}}, {8{be_eff[2]}}, {8{be_eff[1]}}, {8{be_eff[0]}}};
        if (!err) begin
            if (we) model[sel][widx] = (model[sel][widx] & ~mask) | (wdata & mask);
            else    rdata = model[sel][widx];
        end
    endtask

    task automatic do_req(input int sel, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          output logic [31:0] rdata, output logic err);
        logic [31:0] er;
        logic        ee;
        int          lat;
        model_txn(sel, we, addr, wdata, be, er, ee);
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        if (sel == 1) req_valid0 = 1'b1; else req_valid = 1'b1;
        chk("ready_before", (sel == 1) ? req_ready0 : req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_valid0 = 1'b0;
        lat = 1;
        while (!((sel == 1) ? rsp_valid0 : rsp_valid) && lat < 20) begin
            if (sel == 0) begin
                req_valid = 1'($urandom); req_we = 1'($urandom);
                req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        req_valid = 1'b0;
        chk("latency", 32'(lat), (sel == 1) ? 32'd1 : 32'd3);
        rdata = (sel == 1) ? rsp_rdata0 : rsp_rdata;
        err   = (sel == 1) ? rsp_err0 : rsp_err;
        chk("rdata", rdata, er);
        chk("err", {31'd0, err}, {31'd0, ee});
        @(posedge clk); #1;
        chk("valid_one_cycle", (sel == 1) ? rsp_valid0 : rsp_valid, 0);
        chk("ready_after", (sel == 1) ? req_ready0 : req_ready, 1);
        chk("rdata_hold", (sel == 1) ? rsp_rdata0 : rsp_rdata, er);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, addrs [3], acc [3];
        logic        er, acc_now;
        int          mism, k, t, sawv;

        reset = 1'b1; req_valid = 1'b0; req_valid0 = 1'b0;
        req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_req_ready", req_ready, 1);
        reset = 1'b0;

        for (int i = 0; i < DEPTH; i++) do_req(0, 1'b1, 32'(i * 4), $urandom, 4'hF, rd, er);

        vt[0] = '{1'b1, 32'h04,  32'd66,       32'd0,   1'b0};
        vt[1] = '{1'b1, 32'h0C,  32'h99,       32'd0,   1'b0};
        vt[2] = '{1'b0, 32'h04,  32'd0,        32'd66,  1'b0};
        vt[3] = '{1'b1, 32'h0C,  32'd187,      32'd0,   1'b0};
        vt[4] = '{1'b0, 32'h0C,  32'd0,        32'd187, 1'b0};
        vt[5] = '{1'b0, 32'h100, 32'd0,        32'd0,   1'b1};
        vt[6] = '{1'b1, 32'h102, 32'hDEADBEEF, 32'd0,   1'b1};
        vt[7] = '{1'b1, 32'h0D,  32'd1,        32'd0,   1'b1};
        vt[8] = '{1'b0, 32'h0C,  32'd0,        32'd187, 1'b0};
        for (int i = 0; i < 9; i++) begin
            do_req(0, vt[i].we, vt[i].addr, vt[i].wdata, 4'hF, rd, er);
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vt[i].exp_err});
        end
        mism = 0;
        for (int i = 0; i < DEPTH; i++) if (dut.RAM[i] !== model[0][i]) mism++;
        chk("ram_image_after_table", 32'(mism), 0);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 71) * 4);
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            do_req(0, 1'($urandom), a, $urandom, 4'($urandom), rd, er);
        end

        // Reset in the middle of a store's wait states abandons it.
        do_req(0, 1'b1, 32'h08, 32'd121, 4'hF, rd, er);
        req_we = 1'b1; req_addr = 32'h08; req_wdata = 32'd5; req_be = 4'hF; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("rstwait_valid", rsp_valid, 0);
        chk("rstwait_ready", req_ready, 1);
        sawv = 0;
        repeat (2) begin @(posedge clk); #1; if (rsp_valid) sawv++; end
        reset = 1'b0;
        chk("rstwait_ready_release", req_ready, 1);
        repeat (4) begin @(posedge clk); #1; if (rsp_valid) sawv++; end
        chk("rstwait_no_rsp", 32'(sawv), 0);
        chk("rstwait_ram2", dut.RAM[2], 32'd121);
        do_req(0, 1'b0, 32'h08, 32'd0, 4'hF, rd, er);
        chk("rstwait_load", rd, 32'd121);

        // Zero wait states, request held valid for three back-to-back loads.
        addrs[0] = 32'h20; addrs[1] = 32'h24; addrs[2] = 32'h28;
        for (int i = 0; i < 3; i++) do_req(1, 1'b1, addrs[i], $urandom, 4'hF, rd, er);
        req_we = 1'b0; req_addr = addrs[0]; req_valid0 = 1'b1;
        k = 0; t = 0;
        acc[0] = 0; acc[1] = 0; acc[2] = 0;
        while (k < 3 && t < 20) begin
            acc_now = req_ready0;
            @(posedge clk); #1;
            t++;
            if (acc_now) begin
                acc[k] = 32'(t);
                chk("b2b_valid", rsp_valid0, 1);
                chk("b2b_rdata", rsp_rdata0, model[1][addrs[k] / 4]);
                k++;
                if (k < 3) req_addr = addrs[k];
            end else begin
                chk("b2b_gap_novalid", rsp_valid0, 0);
            end
        end
        req_valid0 = 1'b0;
        chk("b2b_count", 32'(k), 3);
        chk("b2b_spacing1", acc[1] - acc[0], 2);
        chk("b2b_spacing2", acc[2] - acc[1], 2);
        @(posedge clk); #1;

`ifdef DMEM_BYTE_STROBE_EN
        do_req(0, 1'b1, 32'h10, 32'h11223344, 4'hF, rd, er);
        do_req(0, 1'b1, 32'h10, 32'hAABBCCDD, 4'b0101, rd, er);
        chk("strobe_ram4", dut.RAM[4], 32'h11BB33DD);
        do_req(0, 1'b1, 32'h10, 32'h55555555, 4'b0000, rd, er);
        chk("strobe_be0_ram4", dut.RAM[4], 32'h11BB33DD);
        do_req(0, 1'b0, 32'h10, 32'd0, 4'hF, rd, er);
        chk("strobe_load", rd, 32'h11BB33DD);
`endif

        mism = 0;
        for (int i = 0; i < DEPTH; i++) if (dut.RAM[i] !== model[0][i]) mism++;
        chk("ram_image_final", 32'(mism), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 32-bit words in storage.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted per access (range 0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder accepts a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address; word index = req_addr[31:2].
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle response strobe.
REQ-011 SHALL have port rsp_rdata  output  32  load data; 0 for stores.
REQ-012 SHALL have port rsp_err  output  1  word index >= DEPTH, or req_addr[1:0] != 0; qualified by rsp_valid.

Function
REQ-013 SHALL store words in an array named RAM[0:DEPTH-1], writable and readable by hierarchical access for bench preload and readback.
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 SHALL drive req_ready=1 only in IDLE.
REQ-016 SHALL accept a request on an edge where state=IDLE and req_valid=1; latch we, addr, wdata (and be when strobes are enabled).
REQ-017 SHALL go IDLE->WAIT on acceptance when WAIT_CYCLES>0, IDLE->RESP when WAIT_CYCLES=0.
REQ-018 SHALL remain in WAIT exactly WAIT_CYCLES cycles using a 4-bit down-counter, then go to RESP.
REQ-019 SHALL commit a store to RAM on the edge entering RESP; rsp_rdata=0 for stores.
REQ-020 SHALL register load data on the edge entering RESP, so rsp_rdata is valid throughout RESP.
REQ-021 SHALL assert rsp_valid for exactly one cycle (RESP), then return to IDLE unconditionally.
REQ-022 SHALL give latency: rsp_valid high WAIT_CYCLES+1 cycles after the acceptance edge; maximum throughput one request per WAIT_CYCLES+2 cycles.
REQ-023 SHALL, on an out-of-range or misaligned request, suppress the store, return rsp_rdata=0, and assert rsp_err with rsp_valid.
REQ-024 SHALL ignore req_* inputs outside IDLE; request changes during WAIT/RESP SHALL not affect the latched transaction.
REQ-025 SHALL return, for a load following a store to the same word, the stored value.
REQ-026 SHALL hold rsp_rdata and rsp_err at their last value outside RESP; rsp_valid=0 outside RESP.

Reset
REQ-027 SHALL, on reset assertion (asynchronous), force state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, and clear latched request registers.
REQ-028 SHALL not clear RAM contents on reset, so preloaded data survives.
REQ-029 SHALL, on reset during WAIT, abandon the transaction: no store committed, no rsp_valid.
REQ-030 SHALL keep req_ready=1 while reset is asserted and SHALL accept no request until the first edge after deassertion.

Configuration
REQ-031 SHALL recognise macro DMEM_BYTE_STROBE_EN.
REQ-032 SHALL, with DMEM_BYTE_STROBE_EN defined, add port req_be  input  4  byte-lane enables; a store writes only lanes with be[i]=1 (lane i = bits 8i+7:8i); be=0000 completes normally with no change to RAM.
REQ-033 SHALL, without DMEM_BYTE_STROBE_EN, have no req_be port; every store writes all 32 bits.

Verification
REQ-034 SHALL cover: WAIT_CYCLES=2, RAM[1]=66 preloaded, load 0x04 -> rsp_valid 3 cycles after acceptance, rsp_rdata=66, rsp_err=0.
REQ-035 SHALL cover: store 0x0C data 187 over RAM[3]=0x99 -> RAM[3]=187; subsequent load 0x0C returns 187.
REQ-036 SHALL cover: DEPTH=64, load 0x100 and store 0x102 -> rsp_rdata=0, rsp_err=1 for both, RAM unchanged.
REQ-037 SHALL cover: reset pulsed during WAIT of a store of 5 to 0x08 with RAM[2]=121 -> no rsp_valid, RAM[2]=121, req_ready=1 on first cycle after reset release.
REQ-038 SHALL cover: WAIT_CYCLES=0, req_valid held high for 3 requests -> acceptances every 2 cycles, rsp_valid 1 cycle after each acceptance.
REQ-039 SHALL cover: with DMEM_BYTE_STROBE_EN, RAM[4]=0x11223344, store 0x10 data 0xAABBCCDD be=0101 -> RAM[4]=0x11BB33DD.
